store_buffer_mc: RTL and testbench
==================================

# store_buffer_mc

Parametrised, multi-commit store buffer for the memory system. Sits between the AGU (store enqueue) and the data cache (store drain), and answers load-queue forwarding queries. Holds speculative stores until the ROB commits them, retires up to COMMIT_W stores per cycle, drains committed stores in order, and discards uncommitted stores on flush. Successor to the fixed 2-commit store buffer: depth, ROB-id width and commit width are generalised, and the block adds partial-overlap detection and flush/commit coincidence rules.

## Interface
- DEPTH, 8, entry count; power of two, ≥2
- ROB_W, 5, ROB id width
- COMMIT_W, 2, maximum commits per cycle
- cpu_clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush; discards uncommitted entries
- enqueue_en  in  1  store enqueue request from AGU
- enqueue_address  in  30  word address
- enqueue_data  in  32  store data, byte-lane aligned
- enqueue_bm  in  4  byte mask
- enqueue_io  in  1  uncached/IO store
- enqueue_rob  in  ROB_W  ROB id of store
- enqueue_full  out  1  buffer full; enqueue is ignored
- ins_cmp  out  1  store-completion pulse to ROB
- ins_rob  out  ROB_W  completed ROB id
- commit_i  in  COMMIT_W  commit pulses; popcount = stores committed this cycle
- conflict_address  in  30  load query word address
- conflict_bm  in  4  load query byte mask
- conflict_data_c  out  32  forwarded data
- conflict_bm_c  out  4  forwarded byte mask
- conflict_res_valid  out  1  at least one entry matches query
- conflict_resolvable  out  1  youngest match fully covers conflict_bm
- store_valid  out  1  head entry committed, presented to dcache
- store_address / store_data / store_bm / store_io  out  30/32/4/1  head entry fields
- cache_done  in  1  dcache accepted head store; pop
- store_buffer_empty  out  1  no valid entries

## Operation
- Circular array; pointers head (oldest), cmt (oldest uncommitted), tail (next free); log2(DEPTH)+1 bits each, MSB for wrap disambiguation.
- Regions: [head,cmt) committed, [cmt,tail) speculative. count = tail−head.
- Enqueue: enqueue_en && !enqueue_full && !flush_i writes entry at tail, tail++. Registered ins_cmp=1, ins_rob=enqueue_rob next cycle.
- Commit: cmt += popcount(commit_i). popcount > (tail−cmt) is illegal (assertion).
- Drain: store_valid = (head≠cmt); outputs show head fields. cache_done with store_valid pops: head++. cache_done without store_valid ignored.
- Flush: tail ← cmt after same-cycle commit applied; ins_cmp forced 0 next cycle; committed entries keep draining.
- Forwarding (combinational over all valid entries, committed and speculative): match = valid && addr equal && (bm & conflict_bm)≠0. Select youngest match (scan back from tail−1). conflict_res_valid = any match; conflict_resolvable = youngest match not io && (youngest.bm & conflict_bm)==conflict_bm; conflict_data_c/bm_c = youngest entry data/bm. Entry popping this cycle still participates.
- Reset: all pointers 0; ins_cmp, store_valid, conflict_* outputs 0; enqueue_full 0; store_buffer_empty 1.

## Timing
- enqueue → ins_cmp: 1 cycle. enqueue → forward-visible: 1 cycle.
- commit → store_valid: 1 cycle (if entry is head).
- cache_done → next head on outputs: 1 cycle; back-to-back pops at 1/cycle.
- enqueue_full = (count==DEPTH), registered state; a same-cycle pop does not free the slot for a same-cycle enqueue.
- rst_i dominates flush_i, enqueue, commit, cache_done; mid-drain reset drops the in-flight store (dcache is reset together).

## Configuration
- STORE_BUFFER_FWD_EN defined: forwarding as above.
- Undefined: match detection kept (conflict_res_valid unchanged), conflict_resolvable tied 0, conflict_data_c/bm_c tied 0; loads wait for drain.

## Structure
- Shared package: stb_entry_t (addr, data, bm, io, rob), STB_ADDR_W=30, popcount function.
- Sub-module stb_fwd_select: youngest-match priority selector, parametrised on DEPTH, taking match vector and tail.

## Test plan
- Reset, enqueue 8 stores (DEPTH=8) → enqueue_full=1 after the 8th; 9th enqueue ignored; ins_cmp pulses 8 times with rob 0..7.
- Enqueue 3, commit_i=2'b11 → cmt=2, store_valid next cycle; cache_done ×2 → empty=0, then commit 1, drain 1 → empty=1.
- Enqueue addr 0x10 bm 4'b0011 data 0xAAAA_1111, then addr 0x10 bm 4'b1111 data 0x2222_3333; query 0x10 bm 4'b0001 → res_valid=1, resolvable=1, data 0x2222_3333.
- Single store bm 4'b0011, query bm 4'b1100 → res_valid=0; query bm 4'b0111 → res_valid=1, resolvable=0; IO store full cover → resolvable=0.
- Enqueue 4, commit 1, flush_i with commit_i=1 same cycle → 2 entries remain committed, tail=cmt; drain both → empty=1.
- Fill to wrap-around (pointers cross DEPTH) with interleaved pops; verify count/full/empty and forwarding youngest-first across wrap.

Source files
------------

// File: rtl/store_buffer_mc_pkg.sv
// Shared types for the multi-commit store buffer: entry layout and a popcount helper.
package store_buffer_mc_pkg;
    localparam int STB_ADDR_W    = 30;
    localparam int STB_ROB_MAX_W = 16;

    typedef struct packed {
        logic [STB_ADDR_W-1:0]    addr;
        logic [31:0]              data;
        logic [3:0]               bm;
        logic                     io;
        logic [STB_ROB_MAX_W-1:0] rob;
    } stb_entry_t;

    function automatic logic [7:0] popcount(input logic [31:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c += 8'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/store_buffer_mc_fwd_select.sv
// Youngest-match priority selector: scans backwards from tail-1 and reports the first matching slot.
module stb_fwd_select #(
    parameter int  DEPTH = 8,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] match,
    input  logic [IW-1:0]    tail,
    output logic             hit,
    output logic [IW-1:0]    sel
);
    logic [IW-1:0] idx;

    // Oldest position first so the youngest match is the last one written.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - IW'(k);
            if (match[idx]) begin
                hit = 1'b1;
                sel = idx;
            end
        end
    end
endmodule

// File: rtl/store_buffer_mc.sv
// Multi-commit store buffer: speculative enqueue, up to COMMIT_W commits/cycle, in-order drain, load forwarding.
// Forwarding data path is enabled by defining STORE_BUFFER_FWD_EN; otherwise only match detection is reported.
module store_buffer_mc
    import store_buffer_mc_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int ROB_W    = 5,
    parameter int COMMIT_W = 2
) (
    input  logic                  cpu_clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  enqueue_en,
    input  logic [29:0]           enqueue_address,
    input  logic [31:0]           enqueue_data,
    input  logic [3:0]            enqueue_bm,
    input  logic                  enqueue_io,
    input  logic [ROB_W-1:0]      enqueue_rob,
    output logic                  enqueue_full,
    output logic                  ins_cmp,
    output logic [ROB_W-1:0]      ins_rob,
    input  logic [COMMIT_W-1:0]   commit_i,
    input  logic [29:0]           conflict_address,
    input  logic [3:0]            conflict_bm,
    output logic [31:0]           conflict_data_c,
    output logic [3:0]            conflict_bm_c,
    output logic                  conflict_res_valid,
    output logic                  conflict_resolvable,
    output logic                  store_valid,
    output logic [29:0]           store_address,
    output logic [31:0]           store_data,
    output logic [3:0]            store_bm,
    output logic                  store_io,
    input  logic                  cache_done,
    output logic                  store_buffer_empty
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    stb_entry_t    mem [DEPTH];
    stb_entry_t    wr_ent;
    logic [PW-1:0] head, cmt, tail, count, spec_cnt, cmt_nxt;
    logic [IW-1:0] last_idx;
    logic [IW-1:0] off [DEPTH];
    logic [7:0]    n_cmt;
    logic          enq_fire, pop;
    logic [DEPTH-1:0] match;
    logic          hit;
    logic [IW-1:0] sel;

    assign count              = tail - head;
    assign spec_cnt           = tail - cmt;
    assign enqueue_full       = (count == PW'(DEPTH));
    assign store_buffer_empty = (count == '0);
    assign store_valid        = (head != cmt);
    assign n_cmt              = popcount(32'(commit_i));
    assign cmt_nxt            = cmt + PW'(n_cmt);
    assign enq_fire           = enqueue_en && !enqueue_full && !flush_i;
    assign pop                = cache_done && store_valid;

    always_comb begin
        wr_ent                = '0;
        wr_ent.addr           = enqueue_address;
        wr_ent.data           = enqueue_data;
        wr_ent.bm             = enqueue_bm;
        wr_ent.io             = enqueue_io;
        wr_ent.rob[ROB_W-1:0] = enqueue_rob;
    end

    // Flush rewinds tail to the commit point after this cycle's commits are applied.
    always_ff @(posedge cpu_clk_i) begin
        if (rst_i) begin
            head     <= '0;
            cmt      <= '0;
            tail     <= '0;
            ins_cmp  <= 1'b0;
            last_idx <= '0;
        end else begin
            cmt <= cmt_nxt;
            if (pop) head <= head + PW'(1);
            if (flush_i)       tail <= cmt_nxt;
            else if (enq_fire) tail <= tail + PW'(1);
            ins_cmp <= enq_fire;
            if (enq_fire) last_idx <= tail[IW-1:0];
        end
    end

    always_ff @(posedge cpu_clk_i) begin
        if (enq_fire && !rst_i) mem[tail[IW-1:0]] <= wr_ent;
    end

    always_ff @(posedge cpu_clk_i) begin
        if (!rst_i) assert (int'(n_cmt) <= int'(spec_cnt));
    end

    assign ins_rob       = mem[last_idx].rob[ROB_W-1:0];
    assign store_address = mem[head[IW-1:0]].addr;
    assign store_data    = mem[head[IW-1:0]].data;
    assign store_bm      = mem[head[IW-1:0]].bm;
    assign store_io      = mem[head[IW-1:0]].io;

    // Slot i is live when its distance from head (mod DEPTH) is below the occupancy.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off[i]   = IW'(i) - head[IW-1:0];
            match[i] = ({1'b0, off[i]} < count) && (mem[i].addr == conflict_address)
                       && (|(mem[i].bm & conflict_bm));
        end
    end

    stb_fwd_select #(.DEPTH(DEPTH)) u_fwd_select (
        .match (match),
        .tail  (tail[IW-1:0]),
        .hit   (hit),
        .sel   (sel)
    );

    assign conflict_res_valid  = |match;
    assign conflict_resolvable = FWD_EN && hit && !mem[sel].io
                                 && ((mem[sel].bm & conflict_bm) == conflict_bm);
    assign conflict_data_c     = (FWD_EN && hit) ? mem[sel].data : '0;
    assign conflict_bm_c       = (FWD_EN && hit) ? mem[sel].bm : '0;
endmodule

// File: tb/tb_store_buffer_mc.sv
// Scoreboard bench for store_buffer_mc against a queue-based model of the buffer contents.
module tb_store_buffer_mc;
    localparam int DEPTH = 8, ROB_W = 5, COMMIT_W = 2;

    logic cpu_clk_i = 1'b0;
    logic rst_i, flush_i, enqueue_en, enqueue_io, cache_done;
    logic [29:0] enqueue_address, conflict_address, store_address;
    logic [31:0] enqueue_data, conflict_data_c, store_data;
    logic [3:0]  enqueue_bm, conflict_bm, conflict_bm_c, store_bm;
    logic [ROB_W-1:0] enqueue_rob, ins_rob;
    logic [COMMIT_W-1:0] commit_i;
    logic enqueue_full, ins_cmp, conflict_res_valid, conflict_resolvable;
    logic store_valid, store_io, store_buffer_empty;

    always #5 cpu_clk_i = ~cpu_clk_i;

    store_buffer_mc #(.DEPTH(DEPTH), .ROB_W(ROB_W), .COMMIT_W(COMMIT_W)) dut (
        .cpu_clk_i(cpu_clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .enqueue_en(enqueue_en), .enqueue_address(enqueue_address), .enqueue_data(enqueue_data),
        .enqueue_bm(enqueue_bm), .enqueue_io(enqueue_io), .enqueue_rob(enqueue_rob),
        .enqueue_full(enqueue_full), .ins_cmp(ins_cmp), .ins_rob(ins_rob), .commit_i(commit_i),
        .conflict_address(conflict_address), .conflict_bm(conflict_bm),
        .conflict_data_c(conflict_data_c), .conflict_bm_c(conflict_bm_c),
        .conflict_res_valid(conflict_res_valid), .conflict_resolvable(conflict_resolvable),
        .store_valid(store_valid), .store_address(store_address), .store_data(store_data),
        .store_bm(store_bm), .store_io(store_io), .cache_done(cache_done),
        .store_buffer_empty(store_buffer_empty)
    );

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  bm;
        logic        io;
    } ent_t;

    ent_t q[$];                    // model contents, oldest first; q[0:ncmt-1] committed
    int   ncmt = 0;
    ent_t exp_st[$];               // committed stores awaiting drain, in order
    logic [ROB_W-1:0] exp_rob[$];  // accepted enqueues awaiting ins_cmp
    logic [ROB_W-1:0] next_rob = '0;
    int checks = 0, errors = 0;
    ent_t mon_e;
    logic [ROB_W-1:0] mon_r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge cpu_clk_i) begin
        if (!rst_i) begin
            if (ins_cmp) begin
                checks++;
                if (exp_rob.size() == 0) begin
                    errors++;
                    $display("FAIL ins_cmp: unexpected pulse rob %0h", ins_rob);
                end else begin
                    mon_r = exp_rob.pop_front();
                    checks--;
                    chk("ins_rob", 32'(ins_rob), 32'(mon_r));
                end
            end
            if (store_valid && cache_done) begin
                checks++;
                if (exp_st.size() == 0) begin
                    errors++;
                    $display("FAIL drain: unexpected store addr %0h", store_address);
                end else begin
                    mon_e = exp_st.pop_front();
                    checks--;
                    chk("store_address", 32'(store_address), 32'(mon_e.a));
                    chk("store_data", store_data, mon_e.d);
                    chk("store_bm", 32'(store_bm), 32'(mon_e.bm));
                    chk("store_io", 32'(store_io), 32'(mon_e.io));
                end
            end
        end
    end

    function automatic logic [COMMIT_W-1:0] enc(input int n);
        logic [COMMIT_W-1:0] v;
        int placed, b;
        v = '0;
        placed = 0;
        while (placed < n) begin
            b = $urandom_range(0, COMMIT_W - 1);
            if (!v[b]) begin
                v[b] = 1'b1;
                placed++;
            end
        end
        return v;
    endfunction

    // One clock: drive inputs, advance the model the way the rules say, then step past the edge.
    task automatic cyc(input bit en, input logic [29:0] a, input logic [31:0] d, input logic [3:0] bm,
                       input bit io, input int n, input bit fl, input bit done);
        int  spec;
        bit  full;
        ent_t e;
        spec = q.size() - ncmt;
        full = (q.size() == DEPTH);
        if (n > spec) n = spec;
        enqueue_en = en; enqueue_address = a; enqueue_data = d; enqueue_bm = bm;
        enqueue_io = io; enqueue_rob = next_rob; commit_i = enc(n);
        flush_i = fl; cache_done = done;
        if (done && ncmt > 0) begin
            void'(q.pop_front());
            ncmt--;
        end
        for (int k = 0; k < n; k++) exp_st.push_back(q[ncmt + k]);
        ncmt += n;
        if (fl) begin
            while (q.size() > ncmt) void'(q.pop_back());
        end else if (en && !full) begin
            e = '{a: a, d: d, bm: bm, io: io};
            q.push_back(e);
            exp_rob.push_back(next_rob);
        end
        next_rob++;
        @(posedge cpu_clk_i);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_full"}, 32'(enqueue_full), 32'(q.size() == DEPTH));
        chk({tag, "_empty"}, 32'(store_buffer_empty), 32'(q.size() == 0));
        chk({tag, "_store_valid"}, 32'(store_valid), 32'(ncmt > 0));
    endtask

    task automatic query(input string tag, input logic [29:0] a, input logic [3:0] bm);
        bit hit;
        ent_t y;
        hit = 1'b0;
        y = '0;
        conflict_address = a;
        conflict_bm = bm;
        #1;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == a && (q[i].bm & bm) != 0) begin
                hit = 1'b1;
                y = q[i];
                break;
            end
        end
        chk({tag, "_res_valid"}, 32'(conflict_res_valid), 32'(hit));
`ifdef STORE_BUFFER_FWD_EN
        chk({tag, "_resolvable"}, 32'(conflict_resolvable), 32'(hit && !y.io && ((y.bm & bm) == bm)));
        chk({tag, "_data"}, conflict_data_c, hit ? y.d : 32'h0);
        chk({tag, "_bm"}, 32'(conflict_bm_c), hit ? 32'(y.bm) : 32'h0);
`else
        chk({tag, "_resolvable"}, 32'(conflict_resolvable), 32'h0);
        chk({tag, "_data"}, conflict_data_c, 32'h0);
        chk({tag, "_bm"}, 32'(conflict_bm_c), 32'h0);
`endif
    endtask

    task automatic drain_all();
        for (int k = 0; k < 200 && q.size() > 0; k++) cyc(0, '0, '0, '0, 0, COMMIT_W, 0, 1);
        check_state("drained");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; flush_i = 0; enqueue_en = 0; enqueue_address = '0; enqueue_data = '0;
        enqueue_bm = '0; enqueue_io = 0; enqueue_rob = '0; commit_i = '0; cache_done = 0;
        conflict_address = '0; conflict_bm = '0;
        repeat (3) @(posedge cpu_clk_i);
        #1;
        rst_i = 1'b0;
        check_state("reset");
        query("reset_q", 30'h10, 4'hF);

        // fill to full; the ninth enqueue must be dropped
        for (int i = 0; i < 9; i++) cyc(1, 30'h100 + 30'(i), $urandom, 4'hF, 0, 0, 0, 0);
        check_state("fill");
        cyc(0, '0, '0, '0, 0, 0, 0, 0);
        drain_all();

        // commit two of three, drain them, then the last
        for (int i = 0; i < 3; i++) cyc(1, 30'h200 + 30'(i), $urandom, 4'hF, 0, 0, 0, 0);
        cyc(0, '0, '0, '0, 0, 2, 0, 0);
        check_state("cmt2");
        cyc(0, '0, '0, '0, 0, 0, 0, 1);
        cyc(0, '0, '0, '0, 0, 0, 0, 1);
        check_state("pop2");
        cyc(0, '0, '0, '0, 0, 1, 0, 0);
        cyc(0, '0, '0, '0, 0, 0, 0, 1);
        check_state("pop3");

        // youngest-first forwarding and partial overlap
        cyc(1, 30'h10, 32'hAAAA_1111, 4'b0011, 0, 0, 0, 0);
        cyc(1, 30'h10, 32'h2222_3333, 4'b1111, 0, 0, 0, 0);
        query("fwd_young", 30'h10, 4'b0001);
        drain_all();
        cyc(1, 30'h10, 32'h5555_6666, 4'b0011, 0, 0, 0, 0);
        query("fwd_disjoint", 30'h10, 4'b1100);
        query("fwd_partial", 30'h10, 4'b0111);
        cyc(1, 30'h20, 32'h7777_8888, 4'b1111, 1, 0, 0, 0);
        query("fwd_io", 30'h20, 4'b1111);
        drain_all();

        // flush coinciding with a commit
        for (int i = 0; i < 4; i++) cyc(1, 30'h300 + 30'(i), $urandom, 4'hF, 0, 0, 0, 0);
        cyc(0, '0, '0, '0, 0, 1, 0, 0);
        cyc(0, '0, '0, '0, 0, 1, 1, 0);
        check_state("flush");
        query("flush_gone", 30'h302, 4'hF);
        query("flush_kept", 30'h301, 4'hF);
        drain_all();

        // randomized traffic with pointer wrap
        for (int c = 0; c < 1500; c++) begin
            check_state("rnd");
            query("rnd_q", 30'h10 + 30'($urandom_range(0, 3)), 4'($urandom_range(1, 15)));
            cyc($urandom_range(0, 9) < 6, 30'h10 + 30'($urandom_range(0, 3)), $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
                $urandom_range(0, COMMIT_W), $urandom_range(0, 32) == 0, $urandom_range(0, 1) == 1);
        end
        drain_all();
        repeat (3) cyc(0, '0, '0, '0, 0, 0, 0, 0);
        chk("rob_pending", 32'(exp_rob.size()), 32'h0);
        chk("store_pending", 32'(exp_st.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
